// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues single-word imem reads and presents
// each fetched word with its PC to decode; redirects squash wrong-path work.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc, pc_n;
  logic [XLEN-1:0]   fa, fa_n;
  logic [XLEN-1:0]   inst_n, inst_pc_n;
  logic [XLEN-1:0]   rpc;
  logic              req_n, valid_n;

  assign rpc       = redirect_pc & WORD_MASK;
  assign imem_addr = fa;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      fa         <= RESET_PC;
      inst       <= NOP;
      inst_pc    <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      fa         <= fa_n;
      inst       <= inst_n;
      inst_pc    <= inst_pc_n;
      imem_req   <= req_n;
      inst_valid <= valid_n;
    end
  end

  // Next-state logic; a pending request is never abandoned, only drained.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    fa_n      = fa;
    inst_n    = inst;
    inst_pc_n = inst_pc;
    case (state)
      IDLE: begin
        state_n = FETCH;
        if (redirect_valid) begin
          pc_n = rpc;
          fa_n = rpc;
        end else begin
          fa_n = pc;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_n = rpc;
            fa_n = rpc;
          end else begin
            inst_n    = imem_rdata;
            inst_pc_n = fa;
            pc_n      = fa + XLEN'(4);
            state_n   = HOLD;
          end
        end else if (redirect_valid) begin
          pc_n    = rpc;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_n = rpc;
        if (imem_ack) begin
          fa_n    = redirect_valid ? rpc : pc;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = rpc;
          fa_n    = rpc;
          state_n = FETCH;
        end else if (inst_ready) begin
          fa_n    = pc;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
    req_n   = (state_n == FETCH) || (state_n == DRAIN);
    valid_n = (state_n == HOLD);
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic against a
// pending/stale/held transaction model and an in-order PC stream tracker.
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] K      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: an outstanding request (possibly stale), a held instruction, next PC.
  bit          m_idle, m_req, m_stale, m_held;
  logic [31:0] m_pc, m_addr, m_inst, m_ipc;
  logic [31:0] exp_xfer_pc;

  int          wait_cfg = 0;
  int          mem_cnt = 0;
  bit          prev_req = 1'b0, prev_ack = 1'b0, new_issue = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] issue_log[$];
  logic [31:0] xfer_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(m_req));
    chk("inst_valid", 32'(inst_valid), 32'(m_held));
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
    new_issue = imem_req && (!prev_req || prev_ack);
    if (new_issue) issue_log.push_back(imem_addr);
    prev_req  = imem_req;
    prev_addr = imem_addr;
  endtask

  task automatic drive_step(input bit r, input bit rd, input logic [31:0] rpc_in, input bit rdy);
    bit          ack, xfer;
    logic [31:0] rpc, rdata;
    ack   = !r && imem_req && (mem_cnt >= wait_cfg);
    rdata = ack ? (imem_addr ^ K) : $urandom;
    rst = r; imem_ack = ack; imem_rdata = rdata;
    redirect_valid = rd; redirect_pc = rpc_in; inst_ready = rdy;
    rpc  = rpc_in & 32'hFFFF_FFFC;
    xfer = !r && m_held && rdy && !rd;
    if (xfer) begin
      chk("xfer_word", inst, exp_xfer_pc ^ K);
      chk("xfer_pc", inst_pc, exp_xfer_pc);
      xfer_log.push_back(exp_xfer_pc);
      exp_xfer_pc = exp_xfer_pc + 32'd4;
    end
    if (r) exp_xfer_pc = RST_PC;
    else if (rd) exp_xfer_pc = rpc;
    if (r) begin
      m_idle = 1; m_req = 0; m_stale = 0; m_held = 0;
      m_pc = RST_PC; m_addr = RST_PC; m_inst = 32'h0000_0013; m_ipc = '0;
    end else if (m_idle) begin
      m_idle = 0;
      if (rd) m_pc = rpc;
      m_addr = m_pc; m_req = 1; m_stale = 0;
    end else if (m_req) begin
      if (ack) begin
        if (m_stale || rd) begin
          if (rd) m_pc = rpc;
          m_addr = m_pc; m_stale = 0;
        end else begin
          m_held = 1; m_inst = rdata; m_ipc = m_addr;
          m_pc = m_addr + 32'd4; m_req = 0;
        end
      end else if (rd) begin
        m_pc = rpc; m_stale = 1;
      end
    end else if (m_held) begin
      if (rd) begin
        m_held = 0; m_pc = rpc; m_addr = rpc; m_req = 1;
      end else if (rdy) begin
        m_held = 0; m_addr = m_pc; m_req = 1;
      end
    end
    if (r || ack) mem_cnt = 0;
    else if (imem_req) mem_cnt++;
    prev_ack = ack;
    @(posedge clk);
  endtask

  task automatic step(input bit r, input bit rd, input logic [31:0] rpc_in, input bit rdy);
    sample();
    drive_step(r, rd, rpc_in, rdy);
  endtask

  task automatic wait_issue(input string tag);
    for (int i = 0; i < 200; i++) begin
      sample();
      if (new_issue) return;
      drive_step(0, 0, '0, 1);
    end
    chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200; i++) begin
      sample();
      if (inst_valid) return;
      drive_step(0, 0, '0, 1);
    end
    chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    bit          v[10];
    logic [31:0] hp;
    int          n;

    // Reset values and first-request timing
    drive_step(1, 0, '0, 1);
    sample();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0000_0100);
    drive_step(1, 0, '0, 1);
    issue_log.delete();
    xfer_log.delete();
    sample();
    chk("first_req_c1", 32'(imem_req), 32'd0);
    drive_step(0, 0, '0, 1);
    for (int i = 0; i < 10; i++) begin
      sample();
      v[i] = inst_valid;
      drive_step(0, 0, '0, 1);
    end
    chk("first_req_c2", 32'(v[0] == 1'b0 && issue_log.size() > 0), 32'd1);
    chk("issue_cnt", 32'(issue_log.size() >= 3), 32'd1);
    if (issue_log.size() >= 3) begin
      chk("issue0", issue_log[0], 32'h0000_0100);
      chk("issue1", issue_log[1], 32'h0000_0104);
      chk("issue2", issue_log[2], 32'h0000_0108);
    end
    chk("xfer_cnt", 32'(xfer_log.size() >= 2), 32'd1);
    if (xfer_log.size() >= 2) begin
      chk("xfer0", xfer_log[0], 32'h0000_0100);
      chk("xfer1", xfer_log[1], 32'h0000_0104);
    end
    for (int i = 0; i < 10; i++) chk("valid_alt", 32'(v[i]), 32'(i % 2 == 1));

    // Decode stalls for 5 cycles in HOLD
    wait_valid("to_hold");
    hp = m_ipc;
    drive_step(0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      drive_step(0, 0, '0, 0);
    end
    n = xfer_log.size();
    step(0, 0, '0, 1);
    sample();
    chk("stall_xfer", 32'(xfer_log.size()), 32'(n + 1));
    chk("stall_next", 32'(new_issue), 32'd1);
    chk("stall_next_addr", issue_log[$], hp + 32'd4);
    drive_step(0, 0, '0, 1);

    // 3 wait cycles, redirect in the 2nd wait cycle
    wait_cfg = 3;
    wait_issue("ws_issue");
    hp = m_addr;
    drive_step(0, 0, '0, 1);
    step(0, 1, 32'h0000_0200, 1);
    step(0, 0, '0, 1);
    sample();
    chk("drain_addr", imem_addr, hp);
    drive_step(0, 0, '0, 1);
    sample();
    chk("drain_reissue", 32'(new_issue), 32'd1);
    chk("drain_next", issue_log[$], 32'h0000_0200);
    drive_step(0, 0, '0, 1);
    n = xfer_log.size();
    for (int i = 0; i < 40 && xfer_log.size() == n; i++) step(0, 0, '0, 1);
    chk("drain_first_xfer", xfer_log[$], 32'h0000_0200);

    // Redirect coinciding with ack, then redirect in HOLD with ready high
    wait_cfg = 0;
    wait_issue("ra_issue");
    drive_step(0, 1, 32'h0000_0600, 1);
    sample();
    chk("ra_valid", 32'(inst_valid), 32'd0);
    chk("ra_next", issue_log[$], 32'h0000_0600);
    drive_step(0, 0, '0, 1);
    wait_valid("rh_valid");
    n = xfer_log.size();
    drive_step(0, 1, 32'h0000_0700, 1);
    sample();
    chk("rh_noxfer", 32'(xfer_log.size()), 32'(n));
    chk("rh_valid", 32'(inst_valid), 32'd0);
    chk("rh_next", issue_log[$], 32'h0000_0700);
    drive_step(0, 0, '0, 1);

    // Two redirects during DRAIN; newest wins
    wait_cfg = 4;
    wait_issue("dd_issue");
    drive_step(0, 1, 32'h0000_0300, 1);
    step(0, 1, 32'h0000_0400, 1);
    wait_issue("dd_next");
    chk("dd_next_addr", issue_log[$], 32'h0000_0400);
    drive_step(0, 0, '0, 1);
    wait_valid("dd_valid");
    chk("dd_inst_pc", inst_pc, 32'h0000_0400);
    drive_step(0, 1, 32'h0000_0503, 1);
    sample();
    chk("unaligned_next", issue_log[$], 32'h0000_0500);
    drive_step(0, 0, '0, 1);

    // PC wrap
    wait_cfg = 0;
    wait_valid("wrap_valid");
    drive_step(0, 1, 32'hFFFF_FFFC, 1);
    sample();
    chk("wrap_top", issue_log[$], 32'hFFFF_FFFC);
    drive_step(0, 0, '0, 1);
    wait_issue("wrap_issue");
    chk("wrap_zero", issue_log[$], 32'h0000_0000);
    drive_step(0, 0, '0, 1);

    // Reset with a pending request
    wait_cfg = 3;
    wait_issue("mr_issue");
    drive_step(0, 0, '0, 1);
    step(1, 0, '0, 1);
    sample();
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_valid", 32'(inst_valid), 32'd0);
    drive_step(0, 0, '0, 1);
    wait_issue("mr_restart");
    chk("mr_restart_addr", issue_log[$], RST_PC);
    drive_step(0, 0, '0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) wait_cfg = int'($urandom_range(0, 3));
      step(($urandom % 500) == 0, ($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);
    end
    sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit for the SRV1 core: owns the program counter, issues single-word read requests to instruction memory, and hands each fetched 32-bit instruction with its PC to the decode stage over a valid/ready handshake. The decode stage's opcode field and control-word lookup are fed from this block's output. Branch/jump redirects from execute override the PC and squash any in-flight or held wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request; held high until the ack cycle
- imem_addr  out  32  word address of the request, bits [1:0] always 0
- imem_ack  in  1  one-cycle response strobe; valid only while imem_req=1
- imem_rdata  in  32  instruction word, valid in the imem_ack cycle
- inst_valid  out  1  registered; inst/inst_pc hold a fetched instruction
- inst_ready  in  1  decode accepts instruction
- inst  out  32  fetched instruction word
- inst_pc  out  32  address inst was fetched from
- redirect_valid  in  1  one-cycle redirect strobe from execute (taken branch, JAL, JALR)
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored (forced to 0)

## Operation
- State register with four states: IDLE, FETCH, DRAIN, HOLD. Registers: pc (next fetch address), fa (address of the outstanding request), inst, inst_pc.
- imem_req = (state==FETCH || state==DRAIN); imem_addr = fa; inst_valid = (state==HOLD).
- Transfer to decode occurs when inst_valid && inst_ready && !redirect_valid; redirect_valid always wins.
- IDLE: entered only from reset. Next cycle → FETCH, fa<=pc. A redirect in IDLE sets pc/fa to redirect_pc.
- FETCH:
  - ack && !redirect: inst<=imem_rdata, inst_pc<=fa, pc<=fa+4, → HOLD.
  - ack && redirect: the response is discarded, fa<=pc<=redirect_pc, stay FETCH. A new request is issued next cycle.
  - !ack && redirect: pc<=redirect_pc, → DRAIN. The request at fa stays pending and unchanged.
  - !ack && !redirect: stay FETCH. fa and req are held stable.
- DRAIN: waits for the ack of the abandoned request.
  - ack: the data is discarded, fa<=pc, → FETCH.
  - A further redirect in DRAIN overwrites pc; the newest redirect wins. If ack and redirect coincide, fa<=redirect_pc.
- HOLD:
  - redirect: the held instruction is dropped, fa<=pc<=redirect_pc, → FETCH.
  - transfer: fa<=pc, → FETCH.
  - else: hold inst/inst_pc stable.
- PC arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC wraps to 32'h0000_0000.
- Bus rule: while imem_req=1 and no ack has occurred, imem_addr must not change. The block never abandons a request; it drains it.

## Timing
- Reset values: state=IDLE, pc=fa=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0.
- The first imem_req rises in the second cycle after rst deasserts. IDLE lasts one cycle.
- Zero-wait memory (ack in the same cycle as req):
  - FETCH→HOLD, with inst_valid high in the following cycle.
  - Peak throughput is one instruction per 2 cycles.
- Each memory wait cycle adds one cycle of latency.
- Redirect-to-new-request latency is 1 cycle from FETCH (with ack) or from HOLD. From DRAIN it is 1 cycle after the stale ack.
- A reset asserted mid-transaction aborts everything on the next edge. Instruction memory shares rst and drops any pending ack.
- No combinational path from inputs to outputs. All outputs are functions of registered state only.

## Test plan
- Reset release with RESET_PC=32'h0000_0100 and zero-wait memory returning addr^32'hA5A5_0000:
  - Required: requests at 0x100, 0x104, 0x108.
  - Required: inst_pc/inst pairs match, inst_valid every other cycle.
- inst_ready held low for 5 cycles in HOLD:
  - Required: inst/inst_pc stable, imem_req=0.
  - Required: one transfer when ready rises, then a request at pc+4.
- Memory with 3 wait cycles plus redirect_pc=32'h0000_0200 in the 2nd wait cycle:
  - Required: imem_addr stays at the old address until ack, and that data is never presented.
  - Required: the next request is at 0x200.
- Redirect coinciding with ack in FETCH, and a redirect in HOLD with inst_ready=1:
  - Required: no transfer, no inst_valid for the squashed word.
  - Required: the next request is at redirect_pc.
- Two redirects (0x300 then 0x400) during DRAIN:
  - Required: only 0x400 is requested.
  - Required: redirect_pc=32'h0000_0503 yields a request at 0x500.
- PC wrap and mid-run reset:
  - Required: a fetch at 0xFFFF_FFFC is followed by 0x0000_0000.
  - Required: rst asserted in FETCH with a pending request gives imem_req=0 and inst_valid=0 next cycle, then a restart at RESET_PC.
